// File: rtl/oiia_tone_sequencer_if.sv
// Pixel position, frame count, run/stop and audio bundle for the tone sequencer.
// master drives frame_counter/x/y/enable and reads sound; slave is the sequencer.
interface oiia_tone_sequencer_if;
    logic [6:0] frame_counter;
    logic [9:0] x;
    logic [9:0] y;
    logic       enable;
    logic       sound;

    modport master (
        output frame_counter, x, y, enable,
        input  sound
    );

    modport slave (
        input  frame_counter, x, y, enable,
        output sound
    );
endinterface

// File: rtl/oiia_tone_sequencer.sv
// Two-phrase, 16-step square-wave melody player timed from scanline/frame ticks.
// Ports: clk, rst_n (async, active low), bus (slave: frame_counter, x, y, enable -> sound).
module oiia_tone_sequencer #(
    parameter int STEP_FRAMES = 8,
    parameter int GAP_FRAMES  = 2
) (
    input logic                  clk,
    input logic                  rst_n,
    oiia_tone_sequencer_if.slave bus
);

    typedef enum logic [1:0] {IDLE, NOTE, GAP} state_t;

    localparam logic [3:0] NOTE_LAST = 4'(STEP_FRAMES - GAP_FRAMES - 1);
    localparam logic [3:0] STEP_LAST = 4'(STEP_FRAMES - 1);

    state_t     state, state_nx;
    logic [3:0] step, step_nx;
    logic [3:0] frame_cnt, frame_cnt_nx;
    logic       phrase, phrase_nx;
    logic [5:0] hp_cnt, hp_cnt_nx;
    logic       tone_q, tone_nx;
    logic       sound_q;
    logic       line_tick, frame_tick;
    logic       enter_note, advance;
    logic [2:0] note;
    logic [5:0] half_period;
    logic       unused_ok;

    function automatic logic [2:0] melody(input logic ph, input logic [3:0] s);
        logic [2:0] n;
        n = 3'd0;
        if (!ph) begin
            case (s[2:0])
                3'd0, 3'd1, 3'd6: n = 3'd6;
                3'd2, 3'd3:       n = 3'd1;
                3'd4, 3'd5:       n = 3'd3;
                default:          n = 3'd0;
            endcase
        end else begin
            case (s)
                4'd0, 4'd4:   n = 3'd7;
                4'd1, 4'd5:   n = 3'd5;
                4'd2, 4'd6:   n = 3'd3;
                4'd3, 4'd7:   n = 3'd1;
                4'd8, 4'd10:  n = 3'd6;
                4'd12, 4'd13: n = 3'd4;
                4'd14:        n = 3'd2;
                default:      n = 3'd0;
            endcase
        end
        return n;
    endfunction

    // Half-period in scanlines; the rest code never counts, 60 is a safe filler.
    function automatic logic [5:0] period(input logic [2:0] n);
        logic [5:0] p;
        case (n)
            3'd2:    p = 6'd54;
            3'd3:    p = 6'd48;
            3'd4:    p = 6'd45;
            3'd5:    p = 6'd40;
            3'd6:    p = 6'd36;
            3'd7:    p = 6'd32;
            default: p = 6'd60;
        endcase
        return p;
    endfunction

    assign line_tick   = (bus.x == 10'd0);
    assign frame_tick  = line_tick && (bus.y == 10'd0);
    assign note        = melody(phrase, step);
    assign half_period = period(note);
    assign bus.sound   = sound_q;
    assign unused_ok   = ^bus.frame_counter[5:0];

    always_comb begin
        state_nx     = state;
        step_nx      = step;
        frame_cnt_nx = frame_cnt;
        phrase_nx    = phrase;
        hp_cnt_nx    = hp_cnt;
        tone_nx      = tone_q;
        enter_note   = 1'b0;
        advance      = 1'b0;

        if (!bus.enable) begin
            state_nx     = IDLE;
            step_nx      = 4'd0;
            frame_cnt_nx = 4'd0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (frame_tick) begin
                        state_nx     = NOTE;
                        step_nx      = 4'd0;
                        frame_cnt_nx = 4'd0;
                        phrase_nx    = bus.frame_counter[6];
                        enter_note   = 1'b1;
                    end
                end
                NOTE: begin
                    // Rests leave the divider idle so it stays in range.
                    if (line_tick && note != 3'd0) begin
                        if (hp_cnt == half_period - 6'd1) begin
                            hp_cnt_nx = 6'd0;
                            tone_nx   = ~tone_q;
                        end else begin
                            hp_cnt_nx = hp_cnt + 6'd1;
                        end
                    end
                    if (frame_tick) begin
                        if (frame_cnt == NOTE_LAST) begin
                            if (GAP_FRAMES == 0) begin
                                advance = 1'b1;
                            end else begin
                                state_nx     = GAP;
                                frame_cnt_nx = frame_cnt + 4'd1;
                            end
                        end else begin
                            frame_cnt_nx = frame_cnt + 4'd1;
                        end
                    end
                end
                GAP: begin
                    if (frame_tick) begin
                        if (frame_cnt == STEP_LAST) begin
                            advance = 1'b1;
                        end else begin
                            frame_cnt_nx = frame_cnt + 4'd1;
                        end
                    end
                end
                default: state_nx = IDLE;
            endcase

            if (advance) begin
                state_nx     = NOTE;
                step_nx      = step + 4'd1;
                frame_cnt_nx = 4'd0;
                enter_note   = 1'b1;
                if (step == 4'd15) begin
                    phrase_nx = bus.frame_counter[6];
                end
            end
        end

        // Every note starts from a fresh low phase.
        if (enter_note) begin
            hp_cnt_nx = 6'd0;
            tone_nx   = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            step      <= 4'd0;
            frame_cnt <= 4'd0;
            phrase    <= 1'b0;
            hp_cnt    <= 6'd0;
            tone_q    <= 1'b0;
            sound_q   <= 1'b0;
        end else begin
            state     <= state_nx;
            step      <= step_nx;
            frame_cnt <= frame_cnt_nx;
            phrase    <= phrase_nx;
            hp_cnt    <= hp_cnt_nx;
            tone_q    <= tone_nx;
            sound_q   <= (state == NOTE && note != 3'd0) ? tone_q : 1'b0;
        end
    end

endmodule

// File: tb/tb_oiia_tone_sequencer.sv
// Scoreboard bench: two sequencers (8/2 and legato 5/0) on a shrunken raster,
// checked cycle by cycle against a line/frame counting reference model.
module tb_oiia_tone_sequencer;

    logic clk;
    logic rst_n;

    oiia_tone_sequencer_if bus0 ();
    oiia_tone_sequencer_if bus1 ();

    oiia_tone_sequencer #(.STEP_FRAMES(8), .GAP_FRAMES(2)) dut0 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus0)
    );

    oiia_tone_sequencer #(.STEP_FRAMES(5), .GAP_FRAMES(0)) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int vectors    = 0;
    int miscompares = 0;

    logic [1:0] expq[$];
    bit mon_on = 0;

    // reference model state, one slot per DUT
    bit act[2];
    int stp[2];
    int fr[2];
    int lines[2];
    bit ph[2];

    // raster / stimulus state
    int w = 3;
    int h = 12;
    int col = 0;
    int row = 0;
    bit run_en = 0;
    int drop = 0;
    bit drops_on = 0;
    logic [6:0] fc_r = 7'd0;

    function automatic int mel(bit p, int s);
        int a[8] = '{6, 6, 1, 1, 3, 3, 6, 0};
        int b[16] = '{7, 5, 3, 1, 7, 5, 3, 1, 6, 0, 6, 0, 4, 4, 2, 0};
        return p ? b[s] : a[s % 8];
    endfunction

    function automatic int hper(int n);
        int t[8] = '{60, 60, 54, 48, 45, 40, 36, 32};
        return t[n];
    endfunction

    // e is the sound value expected right after the coming clock edge.
    task automatic model_step(input int i, input bit rst, input bit en,
                              input bit lt, input bit ft, input bit f6,
                              output bit e);
        int sf, gf, n;
        sf = (i == 0) ? 8 : 5;
        gf = (i == 0) ? 2 : 0;
        e = 1'b0;
        if (rst) begin
            act[i] = 0; stp[i] = 0; fr[i] = 0; lines[i] = 0; ph[i] = 0;
            return;
        end
        n = mel(ph[i], stp[i]);
        if (act[i] && fr[i] < sf - gf && n != 0)
            e = ((lines[i] / hper(n)) % 2) != 0;
        if (!en) begin
            act[i] = 0;
            stp[i] = 0;
        end else if (!act[i]) begin
            if (ft) begin
                act[i] = 1; stp[i] = 0; fr[i] = 0; lines[i] = 0; ph[i] = f6;
            end
        end else begin
            if (lt && fr[i] < sf - gf) lines[i]++;
            if (ft) begin
                if (fr[i] == sf - 1) begin
                    stp[i] = (stp[i] + 1) % 16;
                    fr[i] = 0;
                    lines[i] = 0;
                    if (stp[i] == 0) ph[i] = f6;
                end else begin
                    fr[i]++;
                end
            end
        end
    endtask

    task automatic cycle(input bit rst);
        bit lt, ft, e0, e1, en;
        logic [9:0] xv, yv;
        @(negedge clk);
        if (col == 0 && row == 0) begin
            fc_r = fc_r + 7'd1;
            if ($urandom_range(0, 7) == 0) fc_r[6] = ~fc_r[6];
        end
        if (drops_on && drop == 0 && $urandom_range(0, 1499) == 0)
            drop = $urandom_range(1, 6);
        en = run_en && (drop == 0);
        if (drop > 0) drop--;
        lt = (col == 0);
        ft = lt && (row == 0);
        xv = lt ? 10'd0 : 10'($urandom_range(1, 799));
        yv = (row == 0) ? 10'd0 : 10'($urandom_range(1, 524));
        rst_n = !rst;
        bus0.x = xv; bus0.y = yv; bus0.enable = en; bus0.frame_counter = fc_r;
        bus1.x = xv; bus1.y = yv; bus1.enable = en; bus1.frame_counter = fc_r;
        model_step(0, rst, en, lt, ft, fc_r[6], e0);
        model_step(1, rst, en, lt, ft, fc_r[6], e1);
        expq.push_back({e1, e0});
        mon_on = 1;
        col++;
        if (col == w) begin
            col = 0;
            row++;
            if (row == h) row = 0;
        end
    endtask

    task automatic run_frames(input int n);
        for (int f = 0; f < n; f++) begin
            do cycle(0); while (!(col == 0 && row == 0));
        end
    endtask

    initial begin
        logic [1:0] e;
        forever begin
            @(posedge clk);
            #1;
            if (mon_on) begin
                vectors++;
                if (expq.size() == 0) begin
                    miscompares++;
                    $display("FAIL scoreboard_underflow: no expected entry at %0t", $time);
                end else begin
                    e = expq.pop_front();
                    if (bus0.sound !== e[0]) begin
                        miscompares++;
                        $display("FAIL sound_8_2: got %b expected %b at %0t",
                                 bus0.sound, e[0], $time);
                    end
                    vectors++;
                    if (bus1.sound !== e[1]) begin
                        miscompares++;
                        $display("FAIL sound_5_0: got %b expected %b at %0t",
                                 bus1.sound, e[1], $time);
                    end
                end
            end
        end
    end

    initial begin
        int budget;
        rst_n = 1'b0;
        bus0.x = '0; bus0.y = '0; bus0.enable = 1'b0; bus0.frame_counter = '0;
        bus1.x = '0; bus1.y = '0; bus1.enable = 1'b0; bus1.frame_counter = '0;

        // reset held with a raster sweep and random enable
        for (int i = 0; i < 60; i++) begin
            run_en = $urandom_range(0, 1) != 0;
            cycle(1);
        end
        run_en = 0;
        run_frames(3);

        run_en = 1;
        drops_on = 1;
        for (int seg = 0; seg < 6; seg++) begin
            w = $urandom_range(2, 3);
            h = $urandom_range(8, 24);
            run_frames(50);

            if (seg == 2) begin
                // asynchronous reset while a tone is high
                budget = 0;
                while (bus0.sound !== 1'b1 && budget < 5000) begin
                    cycle(0);
                    budget++;
                end
                vectors++;
                if (budget >= 5000) begin
                    miscompares++;
                    $display("FAIL wait_sound_high: got %b expected 1 within 5000 cycles",
                             bus0.sound);
                end
                cycle(1);
                #1;
                vectors++;
                if (bus0.sound !== 1'b0 || bus1.sound !== 1'b0) begin
                    miscompares++;
                    $display("FAIL async_reset: got %b%b expected 00",
                             bus1.sound, bus0.sound);
                end
                cycle(1);
                cycle(1);
                run_frames(1);
            end
        end

        @(posedge clk);
        #2;
        mon_on = 0;
        vectors++;
        if (expq.size() != 0) begin
            miscompares++;
            $display("FAIL scoreboard_drain: got %0d entries left expected 0", expq.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
